// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for the 128x8 data memory: single/burst reads and
// writes over valid/ready command, write-data and read-data ports.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);
    localparam logic [LEN_W-1:0]  CNT_STEP  = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP,
        RD_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_mem_addr_q;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                w_cmd_fire;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_last;
    logic                w_unused_addr_lsb;

    // Word addressing: the byte-address LSB never reaches the memory.
    assign w_unused_addr_lsb = cmd_addr[0];

    assign cmd_ready  = (r_state == IDLE) && !reset;
    assign busy       = (r_state != IDLE);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_wr_fire  = (r_state == WR) && wvalid;
    assign w_rd_fire  = (r_state == RD_HOLD) && rready;
    assign w_last     = (r_cnt == r_len);

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = cmd_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                if (wvalid && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            RD_ADDR: w_state_nxt = RD_CAP;
            RD_CAP:  w_state_nxt = RD_HOLD;
            RD_HOLD: begin
                if (rready) begin
                    w_state_nxt = w_last ? IDLE : RD_ADDR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Burst address/count tracking and the read-data holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_addr <= {cmd_addr[ADDR_W-1:1], 1'b0};
                r_len  <= cmd_len;
                r_cnt  <= '0;
            end
            if (w_wr_fire) begin
                r_addr <= r_addr + ADDR_STEP;
                r_cnt  <= r_cnt + CNT_STEP;
            end
            if (r_state == RD_CAP) begin
                r_rdata  <= mem_dout;
                r_rvalid <= 1'b1;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b0;
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_STEP;
                    r_cnt  <= r_cnt + CNT_STEP;
                end
            end
        end
    end

    always_comb begin
        wready   = 1'b0;
        mem_we   = 1'b0;
        mem_din  = '0;
        mem_addr = r_mem_addr_q;
        case (r_state)
            WR: begin
                wready   = 1'b1;
                mem_we   = wvalid && !reset;
                mem_din  = wdata;
                mem_addr = r_addr;
            end
            RD_ADDR: mem_addr = r_addr;
            default: ;
        endcase
    end

    // Outside address-issue states the memory address holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr_q <= '0;
        end else begin
            r_mem_addr_q <= mem_addr;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 128x8 registered-read memory.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [2:0] cmd_len;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic       mem_init;
    logic [7:0] mem [128];

    int n_total = 0;
    int n_bad   = 0;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [6:0] w);
        return 8'hC3 ^ {1'b0, w};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 128; w++) mem[w] <= init_val(7'(w));
            mem_dout <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr[7:1]] <= mem_din;
            mem_dout <= mem[mem_addr[7:1]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [2:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Beat i carries base+i; gap_n idle cycles are inserted before beat gap_beat.
    task automatic write_burst(input logic [7:0] addr, input int len, input logic [7:0] base,
                               input int gap_beat, input int gap_n);
        logic [7:0] a0;
        logic [7:0] ea;
        a0 = addr & 8'hFE;
        ea = a0;
        do_cmd(1'b1, addr, 3'(len));
        for (int i = 0; i <= len; i++) begin
            ea = a0 + 8'(2 * i);
            if (i == gap_beat) begin
                wvalid = 1'b0;
                for (int k = 0; k < gap_n; k++) begin
                    @(negedge clk);
                    check_eq("wr_gap_we", 32'(mem_we), 32'd0);
                    check_eq("wr_gap_busy", 32'(busy), 32'd1);
                    step();
                end
            end
            wvalid = 1'b1;
            wdata  = base + 8'(i);
            @(negedge clk);
            check_eq("wr_we", 32'(mem_we), 32'd1);
            check_eq("wr_wready", 32'(wready), 32'd1);
            check_eq("wr_addr", 32'(mem_addr), 32'(ea));
            check_eq("wr_din", 32'(mem_din), 32'(base + 8'(i)));
            step();
        end
        wvalid = 1'b0;
        @(negedge clk);
        check_eq("wr_done_busy", 32'(busy), 32'd0);
        check_eq("wr_done_we", 32'(mem_we), 32'd0);
        check_eq("wr_done_addr_hold", 32'(mem_addr), 32'(ea));
        step();
    endtask

    // Expected beat data is base+i, or the memory's power-on pattern when use_init.
    task automatic read_burst(input logic [7:0] addr, input int len, input logic [7:0] base,
                              input bit use_init, input int stall_beat, input int stall_n,
                              input bit poke);
        logic [7:0] a0;
        logic [7:0] ea;
        logic [7:0] ed;
        a0 = addr & 8'hFE;
        ea = a0;
        do_cmd(1'b0, addr, 3'(len));
        for (int i = 0; i <= len; i++) begin
            ea = a0 + 8'(2 * i);
            ed = use_init ? init_val(ea[7:1]) : base + 8'(i);
            rready = (i == stall_beat) ? 1'b0 : 1'b1;
            @(negedge clk);
            check_eq("rd_addr", 32'(mem_addr), 32'(ea));
            check_eq("rd_addr_we", 32'(mem_we), 32'd0);
            check_eq("rd_addr_rvalid", 32'(rvalid), 32'd0);
            step();
            if (poke && i == 1) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 8'h80;
                cmd_len   = 3'd7;
            end
            @(negedge clk);
            check_eq("rd_cap_rvalid", 32'(rvalid), 32'd0);
            if (poke && i == 1) check_eq("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            step();
            cmd_valid = 1'b0;
            if (i == stall_beat) begin
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    check_eq("stall_rvalid", 32'(rvalid), 32'd1);
                    check_eq("stall_rdata", 32'(rdata), 32'(ed));
                    check_eq("stall_addr", 32'(mem_addr), 32'(ea));
                    step();
                end
                rready = 1'b1;
            end
            @(negedge clk);
            check_eq("rd_rvalid", 32'(rvalid), 32'd1);
            check_eq("rd_rdata", 32'(rdata), 32'(ed));
            step();
        end
        rready = 1'b0;
        @(negedge clk);
        check_eq("rd_done_busy", 32'(busy), 32'd0);
        check_eq("rd_done_rvalid", 32'(rvalid), 32'd0);
        check_eq("rd_done_addr_hold", 32'(mem_addr), 32'(ea));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_init  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 3'd0;
        wdata     = 8'h00;
        wvalid    = 1'b0;
        rready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_din", 32'(mem_din), 32'd0);
        check_eq("rst_wready", 32'(wready), 32'd0);
        step();
        reset    = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        step();

        // Single write then two single reads of the same word.
        write_burst(8'h10, 0, 8'hA5, -1, 0);
        read_burst(8'h10, 0, 8'hA5, 1'b0, -1, 0, 1'b0);
        read_burst(8'h11, 0, 8'hA5, 1'b0, -1, 0, 1'b0);

        // 4-beat burst, read back while a command is offered mid-burst.
        write_burst(8'h20, 3, 8'h01, -1, 0);
        read_burst(8'h20, 3, 8'h01, 1'b0, -1, 0, 1'b1);

        // Address wrap 0xFE -> 0x00.
        write_burst(8'hFC, 3, 8'h30, -1, 0);
        read_burst(8'hFC, 3, 8'h30, 1'b0, -1, 0, 1'b0);

        // Write gaps and read backpressure.
        write_burst(8'h60, 2, 8'h90, 1, 2);
        read_burst(8'h60, 2, 8'h90, 1'b0, 1, 5, 1'b0);

        // Reset during beat 2 of an 8-beat write.
        do_cmd(1'b1, 8'h40, 3'd7);
        wvalid = 1'b1;
        wdata  = 8'h70;
        @(negedge clk);
        check_eq("mid_we_beat0", 32'(mem_we), 32'd1);
        step();
        wdata = 8'h71;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_we", 32'(mem_we), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        reset  = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        check_eq("mid_after_busy", 32'(busy), 32'd0);
        check_eq("mid_after_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_after_wready", 32'(wready), 32'd0);
        step();
        read_burst(8'h40, 0, 8'h70, 1'b0, -1, 0, 1'b0);
        read_burst(8'h42, 1, 8'h00, 1'b1, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
